flappy_engine: RTL and testbench

//   Parametrised game-state engine for the terminal Flappy Bird: scene FSM, flap/gravity

---
 rtl/flappy_engine.sv | 130 +++++++++++++
 tb/tb_flappy_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/flappy_engine.sv
// Flappy Bird game-state engine: scene FSM, flap/gravity physics, scrolling pipes,
// collision detection and score, driving the packed scene/bird/gaps/score outputs.
module flappy_engine #(
  parameter int N_PIPES       = 3,
  parameter int HEIGHT        = 40,
  parameter int WIDTH         = 80,
  parameter int GAP_SIZE      = 10,
  parameter int FLAP_TICKS    = 5,
  parameter int GRAV_PERIOD   = 4,
  parameter int SCROLL_PERIOD = 2,
  parameter int BIRD_COL      = 4,
  parameter int PIPE_SPACING  = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              inp,
  output logic [1:0]              scene,
  output logic [8:0]              bird,
  output logic [24*N_PIPES-1:0]   gaps,
  output logic [15:0]             score
);

  localparam logic [1:0] SPLASH   = 2'd0;
  localparam logic [1:0] PLAYING  = 2'd1;
  localparam logic [1:0] GAMEOVER = 2'd2;

  localparam logic [7:0] KEY_SPACE = 8'd32;
  localparam logic [7:0] KEY_R     = 8'd114;
  localparam logic [7:0] ALT0      = 8'd20;
  localparam logic [7:0] TOP       = 8'(HEIGHT - 1);
  localparam logic [7:0] MIN0      = 8'(HEIGHT/2 - GAP_SIZE/2);
  localparam logic [7:0] MAX0      = 8'(HEIGHT/2 - GAP_SIZE/2 + GAP_SIZE);
  localparam logic [7:0] RESPAWN   = 8'(WIDTH - 1);
  localparam logic [7:0] LO        = 8'(BIRD_COL - 2);
  localparam logic [7:0] HI        = 8'(BIRD_COL + 2);
  localparam logic [7:0] FLAP_N    = 8'(FLAP_TICKS);
  localparam logic [7:0] GRAV_LAST = 8'(GRAV_PERIOD - 1);
  localparam logic [7:0] SCR_LAST  = 8'(SCROLL_PERIOD - 1);
  // Degenerate gap sizes leave no room for a random offset; fall back to a fixed minimum.
  localparam int         RMOD      = (HEIGHT - GAP_SIZE - 3 > 0) ? HEIGHT - GAP_SIZE - 3 : 1;

  logic [1:0]                state;
  logic [7:0]                alt, fcnt, gcnt, scnt, eff;
  logic                      flapping, collide;
  logic [N_PIPES-1:0][7:0]   pos, mn, mx, pos_n, mn_n, mx_n;
  logic [15:0]               score_r, passed, lfsr;
  logic [7:0]                rmin;

  assign eff  = (inp == KEY_SPACE) ? FLAP_N : fcnt;
  assign rmin = 8'(32'd2 + 32'(lfsr[7:0]) % RMOD);

  always_comb begin
    collide = 1'b0;
    if (state == PLAYING) begin
      if (alt == 8'd0) collide = 1'b1;
      for (int k = 0; k < N_PIPES; k++)
        if (pos[k] >= LO && pos[k] <= HI && (alt <= mn[k] || alt >= mx[k])) collide = 1'b1;
    end
  end

  // One scroll step: pipes shift left, pos 1 respawns at the right edge with a fresh gap.
  always_comb begin
    passed = '0;
    for (int k = 0; k < N_PIPES; k++) begin
      passed = passed + 16'(pos[k] == LO);
      if (pos[k] == 8'd1) begin
        pos_n[k] = RESPAWN;
        mn_n[k]  = rmin;
        mx_n[k]  = 8'(rmin + 8'(GAP_SIZE));
      end else begin
        pos_n[k] = pos[k] - 8'd1;
        mn_n[k]  = mn[k];
        mx_n[k]  = mx[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SPLASH; alt <= ALT0; flapping <= 1'b0; score_r <= '0;
      fcnt <= '0; gcnt <= '0; scnt <= '0; lfsr <= 16'hACE1;
      for (int k = 0; k < N_PIPES; k++) begin
        pos[k] <= 8'(PIPE_SPACING*(k+1)); mn[k] <= MIN0; mx[k] <= MAX0;
      end
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      case (state)
        SPLASH: if (inp == KEY_SPACE) state <= PLAYING;
        PLAYING: begin
          if (collide) begin
            state <= GAMEOVER; fcnt <= '0; gcnt <= '0; scnt <= '0;
          end else begin
            if (eff != 8'd0) begin
              alt      <= (alt == TOP) ? alt : alt + 8'd1;
              fcnt     <= eff - 8'd1;
              flapping <= 1'b1;
            end else begin
              flapping <= 1'b0;
              if (gcnt == GRAV_LAST) begin
                gcnt <= '0;
                alt  <= (alt == 8'd0) ? alt : alt - 8'd1;
              end else gcnt <= gcnt + 8'd1;
            end
            if (scnt == SCR_LAST) begin
              scnt <= '0; pos <= pos_n; mn <= mn_n; mx <= mx_n;
              score_r <= score_r + passed;
            end else scnt <= scnt + 8'd1;
          end
        end
        GAMEOVER: if (inp == KEY_R) begin
          state <= SPLASH; alt <= ALT0; flapping <= 1'b0; score_r <= '0;
          fcnt <= '0; gcnt <= '0; scnt <= '0;
          for (int k = 0; k < N_PIPES; k++) begin
            pos[k] <= 8'(PIPE_SPACING*(k+1)); mn[k] <= MIN0; mx[k] <= MAX0;
          end
        end
        default: state <= SPLASH;
      endcase
    end
  end

  assign scene = state;
  assign bird  = {alt, flapping};
  assign score = score_r;

  for (genvar k = 0; k < N_PIPES; k++) begin : g_gaps
    assign gaps[24*(N_PIPES-k)-1 -: 24] = {pos[k], mx[k], mn[k]};
  end

endmodule

// File: tb/tb_flappy_engine.sv
// Scoreboard bench for flappy_engine: a behavioural game model queues the expected
// outputs for each driven byte; directed checks cover reset, flap, crash, score and respawn.
module tb_flappy_engine;

  typedef struct packed {
    logic [1:0]  scene;
    logic [8:0]  bird;
    logic [71:0] gaps;
    logic [15:0] score;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, rst2_n = 1'b0;
  logic [7:0]  inp = 8'd0, inp2 = 8'd0;
  logic [1:0]  scene, scene2;
  logic [8:0]  bird, bird2;
  logic [71:0] gaps, gaps2;
  logic [15:0] score, score2;

  int n_checks = 0, n_errors = 0;
  exp_t sb[$];

  // behavioural model state (default parameters)
  int m_scene, m_alt, m_flap, m_fc, m_gc, m_sc, m_score;
  int m_pos[3], m_min[3], m_max[3];
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  flappy_engine dut (
    .clk(clk), .rst_n(rst_n), .inp(inp),
    .scene(scene), .bird(bird), .gaps(gaps), .score(score)
  );

  flappy_engine #(.GAP_SIZE(38)) dut2 (
    .clk(clk), .rst_n(rst2_n), .inp(inp2),
    .scene(scene2), .bird(bird2), .gaps(gaps2), .score(score2)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset(input bit keep_lfsr);
    m_scene = 0; m_alt = 20; m_flap = 0; m_fc = 0; m_gc = 0; m_sc = 0; m_score = 0;
    for (int k = 0; k < 3; k++) begin
      m_pos[k] = 20*(k+1); m_min[k] = 15; m_max[k] = 25;
    end
    if (!keep_lfsr) m_lfsr = 16'hACE1;
  endtask

  function automatic exp_t m_pack();
    exp_t e;
    e.scene = 2'(m_scene);
    e.bird  = {8'(m_alt), 1'(m_flap)};
    e.score = 16'(m_score);
    e.gaps  = '0;
    for (int k = 0; k < 3; k++)
      e.gaps[24*(3-k)-1 -: 24] = {8'(m_pos[k]), 8'(m_max[k]), 8'(m_min[k])};
    return e;
  endfunction

  task automatic m_step(input logic [7:0] b);
    logic [15:0] nl;
    bit col;
    int eff;
    nl  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    col = 0;
    if (m_scene == 1) begin
      if (m_alt == 0) col = 1;
      for (int k = 0; k < 3; k++)
        if (m_pos[k] >= 2 && m_pos[k] <= 6 && (m_alt <= m_min[k] || m_alt >= m_max[k])) col = 1;
    end
    if (m_scene == 0) begin
      if (b == 32) m_scene = 1;
    end else if (m_scene == 1) begin
      if (col) begin
        m_scene = 2; m_fc = 0; m_gc = 0; m_sc = 0;
      end else begin
        eff = (b == 32) ? 5 : m_fc;
        if (eff > 0) begin
          if (m_alt < 39) m_alt++;
          m_fc = eff - 1; m_flap = 1;
        end else begin
          m_flap = 0; m_gc++;
          if (m_gc == 4) begin m_gc = 0; if (m_alt > 0) m_alt--; end
        end
        m_sc++;
        if (m_sc == 2) begin
          m_sc = 0;
          for (int k = 0; k < 3; k++) begin
            if (m_pos[k] == 2) m_score = (m_score + 1) % 65536;
            if (m_pos[k] == 1) begin
              m_pos[k] = 79; m_min[k] = 2 + int'(m_lfsr[7:0]) % 27; m_max[k] = m_min[k] + 10;
            end else m_pos[k]--;
          end
        end
      end
    end else if (b == 114) m_reset(1);
    m_lfsr = nl;
  endtask

  task automatic step(input logic [7:0] b);
    exp_t e;
    inp = b;
    m_step(b);
    sb.push_back(m_pack());
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("scene", 128'(scene), 128'(e.scene));
    chk("bird",  128'(bird),  128'(e.bird));
    chk("gaps",  128'(gaps),  128'(e.gaps));
    chk("score", 128'(score), 128'(e.score));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_scene"}, 128'(scene), 128'd0);
    chk({tag, "_bird"},  128'(bird),  128'h028);
    chk({tag, "_gaps"},  128'(gaps),  128'h14190F_28190F_3C190F);
    chk({tag, "_score"}, 128'(score), 128'd0);
  endtask

  initial begin
    m_reset(0);
    #12;
    chk_reset_vals("reset");
    rst_n = 1'b1; rst2_n = 1'b1;

    // splash ignores everything but space
    step(8'd0); step(8'd114); step(8'd65);
    step(8'd32);
    chk("enter_play", 128'(scene), 128'd1);

    // idle play until the first pipe catches the falling bird
    for (int n = 1; n <= 28; n++) step(8'd0);
    chk("idle28_bird", 128'(bird), 128'(9'd26));
    chk("idle28_pos0", 128'(gaps[71:64]), 128'd6);
    step(8'd0);
    chk("crash_scene", 128'(scene), 128'd2);
    chk("crash_frozen", 128'(bird), 128'(9'd26));
    step(8'd32); step(8'd0);
    chk("over_hold", 128'(gaps[71:64]), 128'd6);

    step(8'd114);
    chk_reset_vals("restart");

    // flap: five climbing edges, then gravity resumes
    step(8'd32);
    step(8'd32);
    chk("flap1", 128'(bird), 128'({8'd21, 1'b1}));
    for (int n = 0; n < 4; n++) step(8'd0);
    chk("flap5", 128'(bird), 128'({8'd25, 1'b1}));
    step(8'd0);
    chk("flap_end", 128'(bird), 128'({8'd25, 1'b0}));

    // async reset between edges, no clock needed
    step(8'd0); step(8'd0);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    m_reset(0);
    #2 rst_n = 1'b1;

    // random play with the scoreboard model
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 15);
      b = (r < 3) ? 8'd32 : (r == 4) ? 8'd114 : (r == 5) ? 8'($urandom_range(0, 255)) : 8'd0;
      step(b);
    end

    // score and respawn with a 38-row gap
    inp = 8'd0;
    inp2 = 8'd32;
    @(posedge clk); #1;
    inp2 = 8'd0;
    chk("g38_play", 128'(scene2), 128'd1);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 37) chk("g38_score37", 128'(score2), 128'd0);
      if (n == 38) begin
        chk("g38_score38", 128'(score2), 128'd1);
        chk("g38_pos38", 128'(gaps2[71:64]), 128'd1);
      end
      if (n == 40) begin
        chk("g38_respawn_pos", 128'(gaps2[71:64]), 128'd79);
        chk("g38_respawn_min", 128'(gaps2[55:48]), 128'd2);
        chk("g38_respawn_max", 128'(gaps2[63:56]), 128'd40);
        chk("g38_bird40", 128'(bird2), 128'({8'd10, 1'b0}));
        chk("g38_scene40", 128'(scene2), 128'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
